pet_stats_engine: RTL and testbench



---
 rtl/pet_pkg.sv | 19 +
 rtl/pet_tick_prescaler.sv | 35 +++
 rtl/pet_stats_engine.sv | 131 +++++++++++++
 tb/tb_pet_stats_engine.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pet_pkg.sv
// Shared types and constants for the pet stat engine and its tick prescaler.
// Holds the FSM state encoding, command opcodes and the stat ceiling helper.
package pet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DEAD = 2'd2
  } pet_state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Largest value a stat of width w can hold.
  function automatic int stat_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/pet_tick_prescaler.sv
// Free-running divider producing a one-cycle tick each time the count wraps.
// The count holds while ena is low and while halt is high.
module pet_tick_prescaler #(
  parameter int DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic halt,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (ena && !halt) begin
        if (cnt_q == LAST) begin
          cnt_q <= '0;
          tick  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pet_stats_engine.sv
// Saturating pet stat counters with random-gated decay on a prescaled tick,
// command-driven feed/play/clean updates, low alarms with hysteresis and a sticky death flag.
module pet_stats_engine
  import pet_pkg::*;
#(
  parameter int         NUM_STATS  = 6,
  parameter int         STAT_W     = 4,
  parameter int         TICK_DIV   = 10_000_000,
  parameter logic [7:0] DECAY_PROB = 8'd128,
  parameter int         LOW_THRESH = 3,
  parameter int         HYST       = 2,
  parameter int         DEAD_TICKS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [7:0]                    rand_in,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [$clog2(NUM_STATS)-1:0]  cmd_stat,
  input  logic                          cmd_op,
  input  logic [STAT_W-1:0]             cmd_amount,
  output logic [NUM_STATS*STAT_W-1:0]   stats_flat,
  output logic [NUM_STATS-1:0]          alarm,
  output logic                          tick_o,
  output logic                          busy,
  output logic                          dead,
  output pet_state_e                    state_dbg
);

  localparam int IDX_W  = $clog2(NUM_STATS);
  localparam int DCNT_W = $clog2(DEAD_TICKS + 1);
  localparam logic [STAT_W-1:0] STAT_MAX = STAT_W'(stat_max(STAT_W));
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_STATS - 1);
  localparam logic [DCNT_W-1:0] DEAD_LIM = DCNT_W'(DEAD_TICKS);

  pet_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              cmd_fire;
  logic              health_zero;

  pet_tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .halt  (dead),
    .tick  (tick_o)
  );

  // Handshake: a command transfers on a cycle where cmd_valid and cmd_ready are
  // both high; cmd_ready is high only in IDLE and does not depend on cmd_valid.
  assign cmd_ready   = (state_q == ST_IDLE);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign busy        = (state_q == ST_SCAN);
  assign dead        = (state_q == ST_DEAD);
  assign state_dbg   = state_q;
  assign health_zero = (stats_flat[STAT_W-1:0] == '0);

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_o) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        // Health has already been decayed by the time the last channel is scanned.
        if (idx_q == LAST_IDX) begin
          if (health_zero) dcnt_d = (dcnt_q == DEAD_LIM) ? dcnt_q : dcnt_q + DCNT_W'(1);
          else             dcnt_d = '0;
          state_d = (dcnt_d == DEAD_LIM) ? ST_DEAD : ST_IDLE;
        end
      end
      ST_DEAD: state_d = ST_DEAD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      if (busy && idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
      else                           idx_q <= '0;
    end
  end

  for (genvar i = 0; i < NUM_STATS; i++) begin : g_ch
    logic [STAT_W-1:0] stat_q, stat_d;
    logic [STAT_W:0]   sum;
    logic              hit_cmd, hit_decay, alarm_q;

    always_comb begin
      hit_cmd   = cmd_fire && (cmd_stat == IDX_W'(i));
      hit_decay = busy && (idx_q == IDX_W'(i)) && (rand_in < DECAY_PROB) && (stat_q != '0);
      sum       = {1'b0, stat_q} + {1'b0, cmd_amount};
      stat_d    = stat_q;
      if (hit_decay) begin
        stat_d = stat_q - STAT_W'(1);
      end else if (hit_cmd) begin
        if (cmd_op == OP_ADD)
          stat_d = (sum > {1'b0, STAT_MAX}) ? STAT_MAX : sum[STAT_W-1:0];
        else if (cmd_op == OP_SUB)
          stat_d = (cmd_amount > stat_q) ? '0 : stat_q - cmd_amount;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stat_q  <= STAT_MAX;
        alarm_q <= 1'b0;
      end else begin
        stat_q <= stat_d;
        // Alarm tracks the registered stat, so it trails a stat change by one cycle.
        if (int'(stat_q) <= LOW_THRESH)             alarm_q <= 1'b1;
        else if (int'(stat_q) >= LOW_THRESH + HYST) alarm_q <= 1'b0;
      end
    end

    assign stats_flat[i*STAT_W +: STAT_W] = stat_q;
    assign alarm[i]                       = alarm_q;
  end

endmodule

// File: tb/tb_pet_stats_engine.sv
// Scenario bench for pet_stats_engine: a reference model pushes expected stat
// vectors into a queue and each completed command or scan pops and compares one.
module tb_pet_stats_engine;
  import pet_pkg::*;

  localparam int NS = 6;
  localparam int SW = 4;
  localparam int TD = 8;
  localparam int W  = NS * SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [7:0]    rand_in = 8'd200;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_stat = '0;
  logic          cmd_op = 1'b0;
  logic [SW-1:0] cmd_amount = '0;
  logic [W-1:0]  stats_flat;
  logic [NS-1:0] alarm;
  logic          tick_o, busy, dead;
  pet_state_e    state_dbg;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  int           m_stat[NS];
  bit           m_alarm[NS];
  int           m_dcnt;
  bit           m_dead;

  pet_stats_engine #(
    .NUM_STATS (NS), .STAT_W (SW), .TICK_DIV (TD), .DECAY_PROB (8'd128),
    .LOW_THRESH (3), .HYST (2), .DEAD_TICKS (4)
  ) dut (
    .clk (clk), .rst_n (rst_n), .ena (ena), .rand_in (rand_in),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_stat (cmd_stat),
    .cmd_op (cmd_op), .cmd_amount (cmd_amount), .stats_flat (stats_flat),
    .alarm (alarm), .tick_o (tick_o), .busy (busy), .dead (dead),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // A tick while scanning must never happen with TICK_DIV >= NUM_STATS+2.
  always @(negedge clk) begin
    if (rst_n && tick_o && busy) begin
      failures++;
      $display("FAIL tick_in_scan: tick_o=1 busy=1, required tick_o=0 while busy");
    end
  end

  function automatic logic [W-1:0] model_flat();
    logic [W-1:0] v;
    for (int i = 0; i < NS; i++) v[i*SW +: SW] = SW'(m_stat[i]);
    return v;
  endfunction

  function automatic logic [NS-1:0] model_alarm();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) begin
      if (m_stat[i] <= 3)      m_alarm[i] = 1'b1;
      else if (m_stat[i] >= 5) m_alarm[i] = 1'b0;
      v[i] = m_alarm[i];
    end
    return v;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; ena = 1'b0; cmd_valid = 1'b0; cmd_stat = '0;
    cmd_op = 1'b0; cmd_amount = '0; rand_in = 8'd200;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NS; i++) begin m_stat[i] = 15; m_alarm[i] = 1'b0; end
    m_dcnt = 0; m_dead = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tick_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL tick_timeout: no tick_o within 40 cycles");
    end
  endtask

  task automatic model_scan(input logic [7:0] r);
    for (int i = 0; i < NS; i++)
      if (r < 8'd128 && m_stat[i] > 0) m_stat[i]--;
    if (m_stat[0] == 0) m_dcnt = (m_dcnt < 4) ? m_dcnt + 1 : 4;
    else                m_dcnt = 0;
    if (m_dcnt == 4) m_dead = 1'b1;
    exp_q.push_back(model_flat());
  endtask

  task automatic scan_wait();
    int n = 0;
    bit done = 1'b0;
    logic [W-1:0] e;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (busy) n++;
      else begin done = 1'b1; break; end
    end
    checks++;
    if (!done || n != NS) begin
      failures++;
      $display("FAIL busy_cycles: got %0d (done=%0b), required %0d", n, done, NS);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scan_queue: expected queue empty");
    end else begin
      e = exp_q.pop_front();
      if (stats_flat !== e) begin
        failures++;
        $display("FAIL scan_stats: got %h, required %h", stats_flat, e);
      end
    end
    @(negedge clk);
    checks++;
    if (alarm !== model_alarm()) begin
      failures++;
      $display("FAIL scan_alarm: got %b, required %b", alarm, model_alarm());
    end
    checks++;
    if (dead !== m_dead) begin
      failures++;
      $display("FAIL scan_dead: got %b, required %b", dead, m_dead);
    end
  endtask

  task automatic do_tick(input logic [7:0] r);
    bit ok;
    rand_in = r;
    ena = 1'b1;
    wait_tick(ok);
    ena = 1'b0;
    if (ok) begin
      model_scan(r);
      scan_wait();
    end
  endtask

  task automatic send_cmd(input int stat, input logic op, input int amt);
    bit ok = 1'b0;
    logic [W-1:0] e;
    for (int c = 0; c < 20; c++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL cmd_ready_timeout: cmd_ready=%b, required 1", cmd_ready);
      return;
    end
    cmd_valid = 1'b1; cmd_stat = 3'(stat); cmd_op = op; cmd_amount = SW'(amt);
    if (stat < NS) begin
      if (op == OP_ADD) m_stat[stat] = (m_stat[stat] + amt > 15) ? 15 : m_stat[stat] + amt;
      else              m_stat[stat] = (amt > m_stat[stat]) ? 0 : m_stat[stat] - amt;
    end
    exp_q.push_back(model_flat());
    @(negedge clk);
    cmd_valid = 1'b0;
    e = exp_q.pop_front();
    if (stats_flat !== e) begin
      failures++;
      $display("FAIL cmd_stats(stat=%0d op=%0b amt=%0d): got %h, required %h",
               stat, op, amt, stats_flat, e);
    end
    @(negedge clk);
    checks++;
    if (alarm !== model_alarm()) begin
      failures++;
      $display("FAIL cmd_alarm: got %b, required %b", alarm, model_alarm());
    end
  endtask

  task automatic test_reset();
    bit ok;
    int n;
    apply_reset();
    checks += 7;
    if (stats_flat !== {W{1'b1}}) begin failures++; $display("FAIL reset_stats: got %h, required %h", stats_flat, {W{1'b1}}); end
    if (alarm !== '0) begin failures++; $display("FAIL reset_alarm: got %b, required 0", alarm); end
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b, required 1", cmd_ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (dead !== 1'b0) begin failures++; $display("FAIL reset_dead: got %b, required 0", dead); end
    if (tick_o !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b, required 0", tick_o); end
    if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d, required %0d", state_dbg, ST_IDLE); end
    rand_in = 8'd200;
    ena = 1'b1;
    n = 0; ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); n++;
      if (tick_o) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || n != TD) begin failures++; $display("FAIL first_tick_delay: got %0d, required %0d", n, TD); end
    n = 0; ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); n++;
      if (tick_o) begin ok = 1'b1; break; end
    end
    ena = 1'b0;
    checks++;
    if (!ok || n != TD) begin failures++; $display("FAIL tick_period: got %0d, required %0d", n, TD); end
    model_scan(8'd200);
    model_scan(8'd200);
    void'(exp_q.pop_front());
    scan_wait();
  endtask

  task automatic test_decay();
    apply_reset();
    repeat (3) do_tick(8'd0);
    checks++;
    if (stats_flat !== 24'hCCCCCC) begin failures++; $display("FAIL decay_three_ticks: got %h, required cccccc", stats_flat); end
    do_tick(8'd200);
    do_tick(8'd127);
    do_tick(8'd128);
    checks++;
    if (stats_flat !== 24'hBBBBBB) begin failures++; $display("FAIL decay_threshold: got %h, required bbbbbb", stats_flat); end
  endtask

  task automatic test_commands();
    apply_reset();
    send_cmd(2, OP_SUB, 1);
    send_cmd(2, OP_ADD, 5);
    send_cmd(3, OP_SUB, 11);
    send_cmd(3, OP_SUB, 9);
    send_cmd(7, OP_ADD, 3);
    send_cmd(4, OP_ADD, 0);
    send_cmd(5, OP_SUB, 15);
    send_cmd(5, OP_ADD, 7);
    checks++;
    if (stats_flat !== 24'h7F0FFF) begin failures++; $display("FAIL cmd_final: got %h, required 7f0fff", stats_flat); end
  endtask

  task automatic test_alarm();
    apply_reset();
    repeat (11) do_tick(8'd0);
    do_tick(8'd0);
    checks++;
    if (alarm !== 6'b111111) begin failures++; $display("FAIL alarm_set: got %b, required 111111", alarm); end
    send_cmd(1, OP_ADD, 1);
    checks++;
    if (alarm[1] !== 1'b1) begin failures++; $display("FAIL alarm_hold: got %b, required 1", alarm[1]); end
    send_cmd(1, OP_ADD, 1);
    checks++;
    if (alarm[1] !== 1'b0) begin failures++; $display("FAIL alarm_clear: got %b, required 0", alarm[1]); end
  endtask

  task automatic test_dead();
    logic [W-1:0] frozen;
    int ticks_seen = 0;
    apply_reset();
    send_cmd(0, OP_SUB, 15);
    repeat (3) do_tick(8'd0);
    send_cmd(0, OP_ADD, 2);
    do_tick(8'd0);
    send_cmd(0, OP_SUB, 1);
    repeat (3) do_tick(8'd0);
    do_tick(8'd0);
    checks += 3;
    if (dead !== 1'b1) begin failures++; $display("FAIL dead_set: got %b, required 1", dead); end
    if (state_dbg !== ST_DEAD) begin failures++; $display("FAIL dead_state: got %0d, required %0d", state_dbg, ST_DEAD); end
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL dead_ready: got %b, required 0", cmd_ready); end
    frozen = model_flat();
    cmd_valid = 1'b1; cmd_stat = 3'd1; cmd_op = OP_ADD; cmd_amount = 4'd5;
    ena = 1'b1; rand_in = 8'd0;
    repeat (30) begin
      @(negedge clk);
      if (tick_o || busy) ticks_seen++;
    end
    cmd_valid = 1'b0; ena = 1'b0;
    checks += 4;
    if (ticks_seen != 0) begin failures++; $display("FAIL dead_ticks: got %0d tick/busy cycles, required 0", ticks_seen); end
    if (stats_flat !== frozen) begin failures++; $display("FAIL dead_frozen: got %h, required %h", stats_flat, frozen); end
    if (dead !== 1'b1) begin failures++; $display("FAIL dead_sticky: got %b, required 1", dead); end
    if (alarm !== model_alarm()) begin failures++; $display("FAIL dead_alarm: got %b, required %b", alarm, model_alarm()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    apply_reset();
    rand_in = 8'd0;
    ena = 1'b1;
    wait_tick(ok);
    ena = 1'b0;
    if (ok) begin
      checks++;
      if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b, required 1", cmd_ready); end
      cmd_valid = 1'b1; cmd_stat = 3'd0; cmd_op = OP_SUB; cmd_amount = 4'd3;
      m_stat[0] = 12;
      model_scan(8'd0);
      scan_wait();
      checks++;
      if (stats_flat !== 24'hEEEEEB) begin failures++; $display("FAIL b2b_stats: got %h, required eeeeeb", stats_flat); end
    end
    ena = 1'b1;
    wait_tick(ok);
    ena = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midscan_busy: got %b, required 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    checks += 4;
    if (stats_flat !== {W{1'b1}}) begin failures++; $display("FAIL midscan_reset_stats: got %h, required %h", stats_flat, {W{1'b1}}); end
    if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL midscan_reset_state: got %0d, required %0d", state_dbg, ST_IDLE); end
    if (busy !== 1'b0) begin failures++; $display("FAIL midscan_reset_busy: got %b, required 0", busy); end
    if (alarm !== '0) begin failures++; $display("FAIL midscan_reset_alarm: got %b, required 0", alarm); end
    rst_n = 1'b1;
    @(negedge clk);
    checks += 2;
    if (stats_flat !== {W{1'b1}}) begin failures++; $display("FAIL post_reset_stats: got %h, required %h", stats_flat, {W{1'b1}}); end
    if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b, required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_decay();
    test_commands();
    test_alarm();
    test_dead();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
